// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, master FSM encoding and
// the width of the wait-state timeout counter.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int TO_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WRESP = 3'd4,
    ST_DONE  = 3'd5
  } mst_state_e;

  // Only OKAY is a clean completion; EXOKAY is unexpected on AXI-Lite.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle between one initiator and one responder.
interface axi_lite_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: turns a core read/write request into
// one AXI-Lite transaction, with an optional wait-state timeout abort.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  axi_lite_if.master  axi
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);
  localparam bit                  TO_EN    = (TIMEOUT_CYCLES != 0);

  mst_state_e          state_q;
  logic [31:0]         addr_q, wdata_q, rdata_q;
  logic [3:0]          wstrb_q;
  logic [TO_CNT_W-1:0] cnt_q;
  logic                req_ready_q, resp_valid_q, err_q;
  logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic                aw_done_q, w_done_q;
  logic                aw_done_d, w_done_d, to_hit;

  // >= rather than == so a handshake taken exactly at the limit cannot let
  // the following response phase run on until the counter wraps.
  assign to_hit    = TO_EN && (cnt_q >= TO_LIMIT);
  assign aw_done_d = aw_done_q | (awvalid_q & axi.awready);
  assign w_done_d  = w_done_q  | (wvalid_q  & axi.wready);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid_i) begin
          addr_q      <= req_addr_i;
          wdata_q     <= req_wdata_i;
          wstrb_q     <= req_wstrb_i;
          cnt_q       <= '0;
          aw_done_q   <= 1'b0;
          w_done_q    <= 1'b0;
          req_ready_q <= 1'b0;
          if (req_wen_i) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= ST_WREQ;
          end else begin
            arvalid_q <= 1'b1;
            state_q   <= ST_RADDR;
          end
        end
        ST_RADDR: begin
          cnt_q <= cnt_q + TO_CNT_W'(1);
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RDATA;
          end else if (to_hit) begin
            arvalid_q    <= 1'b0;
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_RDATA: begin
          cnt_q <= cnt_q + TO_CNT_W'(1);
          if (axi.rvalid) begin
            rdata_q      <= axi.rdata;
            err_q        <= resp_is_err(axi.rresp);
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (to_hit) begin
            rready_q     <= 1'b0;
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_WREQ: begin
          cnt_q <= cnt_q + TO_CNT_W'(1);
          if (aw_done_d && w_done_d) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= ST_WRESP;
          end else if (to_hit) begin
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            awvalid_q <= !aw_done_d;
            wvalid_q  <= !w_done_d;
          end
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
        end
        ST_WRESP: begin
          cnt_q <= cnt_q + TO_CNT_W'(1);
          if (axi.bvalid) begin
            err_q        <= resp_is_err(axi.bresp);
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (to_hit) begin
            bready_q     <= 1'b0;
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.bready  = bready_q;

endmodule
